// File: rtl/dnn_pkg.sv
// Shared types and widths for the DNN datapath stages.
// Used by the conv requantizer and, later, by the FC stage.
package dnn_pkg;

  localparam int ACC_W   = 32;
  localparam int PIX_W   = 8;
  localparam int PIX_MAX = 127;
  localparam int PIX_MIN = -128;

  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;
  localparam int SUM_W   = ACC_W + 1;
  // Signed sum times zero-extended unsigned scale.
  localparam int PROD_W  = SUM_W + SCALE_W + 1;

  typedef struct packed {
    logic [ACC_W-1:0]   bias;
    logic [SCALE_W-1:0] scale;
    logic [SHIFT_W-1:0] shift;
    logic               relu_en;
  } requant_cfg_t;

endpackage

// File: rtl/conv_requant_relu_if.sv
// Accumulator-in / int8-pixel-out bundle of the conv requantization stage.
interface conv_requant_relu_if #(
  parameter int unsigned SAT_CNT_W = 16
);
  import dnn_pkg::*;

  logic                      valid_in;
  logic signed [ACC_W-1:0]   acc_in;
  logic signed [ACC_W-1:0]   bias;
  logic [SCALE_W-1:0]        scale;
  logic [SHIFT_W-1:0]        shift;
  logic                      relu_en;
  logic                      valid_out;
  logic signed [PIX_W-1:0]   pixel_out;
  logic                      frame_done;
  logic [SAT_CNT_W-1:0]      sat_count;

  modport master (
    output valid_in, acc_in, bias, scale, shift, relu_en,
    input  valid_out, pixel_out, frame_done, sat_count
  );

  modport slave (
    input  valid_in, acc_in, bias, scale, shift, relu_en,
    output valid_out, pixel_out, frame_done, sat_count
  );

endinterface

// File: rtl/conv_requant_relu_round_sat.sv
// Combinational round-half-up right shift, optional ReLU and int8 saturation.
module requant_round_sat
  import dnn_pkg::*;
(
  input  logic signed [PROD_W-1:0]  prod,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic                      relu_en,
  output logic signed [PIX_W-1:0]   pixel,
  output logic                      clip
);

  localparam int RND_W = PROD_W + 1;
  localparam logic signed [RND_W-1:0] HI = RND_W'(PIX_MAX);
  localparam logic signed [RND_W-1:0] LO = RND_W'(PIX_MIN);

  logic signed [RND_W-1:0] rnd;
  logic signed [RND_W-1:0] r;
  logic signed [RND_W-1:0] q;
  logic signed [RND_W-1:0] q_relu;

  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = $signed(RND_W'(1) << (shift - SHIFT_W'(1)));
    end
    r = $signed({prod[PROD_W-1], prod}) + rnd;
    q = r >>> shift;
    q_relu = (relu_en && q < 0) ? '0 : q;
    clip = 1'b0;
    pixel = q_relu[PIX_W-1:0];
    if (q_relu > HI) begin
      pixel = HI[PIX_W-1:0];
      clip = 1'b1;
    end else if (q_relu < LO) begin
      pixel = LO[PIX_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/conv_requant_relu.sv
// Requantizes 32-bit conv accumulators to int8 pixels: bias, scale, rounding shift, ReLU, clip.
// Three-stage pipeline (input reg, sum, product) feeding a registered round/saturate output.
module conv_requant_relu
  import dnn_pkg::*;
#(
  parameter int unsigned MAP_WIDTH    = 28,
  parameter int unsigned FRAME_PIXELS = MAP_WIDTH * MAP_WIDTH,
  parameter int unsigned SAT_CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  conv_requant_relu_if.slave bus
);

  localparam int unsigned CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIXELS - 1);

  logic [CNT_W-1:0] in_count_q, in_count_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  requant_cfg_t     shadow_q, shadow_d, live_cfg, cfg_eff;

  logic                    v0_q;
  logic signed [ACC_W-1:0] acc0_q;
  requant_cfg_t            cfg0_q;

  logic                    v1_q;
  logic signed [SUM_W-1:0] sum1_q, sum_d;
  logic [SCALE_W-1:0]      scale1_q;
  logic [SHIFT_W-1:0]      shift1_q;
  logic                    relu1_q;

  logic                     v2_q;
  logic signed [PROD_W-1:0] prod2_q, prod_d;
  logic [SHIFT_W-1:0]       shift2_q;
  logic                     relu2_q;

  logic                    valid_q;
  logic signed [PIX_W-1:0] pixel_q, pixel_d;
  logic                    clip;
  logic                    frame_done_q, frame_done_d;
  logic [SAT_CNT_W-1:0]    sat_q, sat_d;

  requant_round_sat u_round_sat (
    .prod    (prod2_q),
    .shift   (shift2_q),
    .relu_en (relu2_q),
    .pixel   (pixel_d),
    .clip    (clip)
  );

  always_comb begin
    live_cfg = '{bias: bus.bias, scale: bus.scale, shift: bus.shift, relu_en: bus.relu_en};
    // The first pixel of a frame uses the live config; the rest use the captured copy.
    cfg_eff  = (in_count_q == '0) ? live_cfg : shadow_q;
    shadow_d = (bus.valid_in && in_count_q == '0) ? live_cfg : shadow_q;

    in_count_d = in_count_q;
    if (bus.valid_in) begin
      in_count_d = (in_count_q == LAST) ? '0 : in_count_q + CNT_W'(1);
    end

    sum_d  = SUM_W'(acc0_q) + SUM_W'($signed(cfg0_q.bias));
    prod_d = PROD_W'(sum1_q) * PROD_W'($signed({1'b0, scale1_q}));

    out_count_d  = out_count_q;
    frame_done_d = 1'b0;
    sat_d        = sat_q;
    if (v2_q) begin
      out_count_d  = (out_count_q == LAST) ? '0 : out_count_q + CNT_W'(1);
      frame_done_d = (out_count_q == LAST);
      // Previous frame's total stays visible until this frame's first output.
      if (out_count_q == '0) begin
        sat_d = SAT_CNT_W'(clip);
      end else if (sat_q != '1) begin
        sat_d = sat_q + SAT_CNT_W'(clip);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_count_q   <= '0;
      out_count_q  <= '0;
      shadow_q     <= '0;
      v0_q         <= 1'b0;
      acc0_q       <= '0;
      cfg0_q       <= '0;
      v1_q         <= 1'b0;
      sum1_q       <= '0;
      scale1_q     <= '0;
      shift1_q     <= '0;
      relu1_q      <= 1'b0;
      v2_q         <= 1'b0;
      prod2_q      <= '0;
      shift2_q     <= '0;
      relu2_q      <= 1'b0;
      valid_q      <= 1'b0;
      pixel_q      <= '0;
      frame_done_q <= 1'b0;
      sat_q        <= '0;
    end else begin
      in_count_q   <= in_count_d;
      out_count_q  <= out_count_d;
      shadow_q     <= shadow_d;
      v0_q         <= bus.valid_in;
      v1_q         <= v0_q;
      v2_q         <= v1_q;
      valid_q      <= v2_q;
      frame_done_q <= frame_done_d;
      sat_q        <= sat_d;
      if (bus.valid_in) begin
        acc0_q <= bus.acc_in;
        cfg0_q <= cfg_eff;
      end
      if (v0_q) begin
        sum1_q   <= sum_d;
        scale1_q <= cfg0_q.scale;
        shift1_q <= cfg0_q.shift;
        relu1_q  <= cfg0_q.relu_en;
      end
      if (v1_q) begin
        prod2_q  <= prod_d;
        shift2_q <= shift1_q;
        relu2_q  <= relu1_q;
      end
      if (v2_q) begin
        pixel_q <= pixel_d;
      end
    end
  end

  assign bus.valid_out  = valid_q;
  assign bus.pixel_out  = pixel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sat_count  = sat_q;

endmodule

// File: tb/tb_conv_requant_relu.sv
// Randomized bench for conv_requant_relu on a 4x4 map against an arithmetic reference model.
module tb_conv_requant_relu;

  localparam int unsigned MW = 4;
  localparam int unsigned FP = MW * MW;
  localparam int unsigned SW = 16;
  localparam int SAT_MAX = (1 << SW) - 1;

  typedef struct {
    int  due;
    byte pix;
    bit  clip;
    bit  fix_en;
    byte fix;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_requant_relu_if #(.SAT_CNT_W(SW)) bus ();

  conv_requant_relu #(
    .MAP_WIDTH (MW),
    .SAT_CNT_W (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  byte         last_pix = 0;
  int          m_in_cnt = 0;
  int          m_out_cnt = 0;
  int          m_sat = 0;
  int          fd_count = 0;
  int          sh_bias = 0;
  int unsigned sh_scale = 0;
  int          sh_shift = 0;
  bit          sh_relu = 0;

  function automatic void ref_calc(input int acc, input int bias, input int unsigned scale,
                                   input int shift, input bit relu,
                                   output byte pix, output bit clip);
    longint prod, q;
    prod = (longint'(acc) + longint'(bias)) * longint'(scale);
    q = prod + ((shift != 0) ? (longint'(1) << (shift - 1)) : 0);
    q = q >>> shift;
    if (relu && q < 0) q = 0;
    clip = 1'b0;
    if (q > 127) begin
      q = 127;
      clip = 1'b1;
    end else if (q < -128) begin
      q = -128;
      clip = 1'b1;
    end
    pix = byte'(q);
  endfunction

  function automatic int rnd_acc();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(0, 1000) - 500;
      1:       return $urandom_range(0, 200000) - 100000;
      default: return int'($urandom());
    endcase
  endfunction

  task automatic check_outputs();
    exp_t e;
    bit   ev;
    bit   exp_fd;
    ev = (expq.size() > 0) && (expq[0].due == cyc);
    exp_fd = 1'b0;
    checks++;
    assert (bus.valid_out === ev) else begin
      errors++;
      $error("FAIL valid_out cyc=%0d got %b expected %b", cyc, bus.valid_out, ev);
    end
    if (ev) begin
      e = expq.pop_front();
      last_pix = e.pix;
      exp_fd = (m_out_cnt == FP - 1);
      if (m_out_cnt == 0) m_sat = int'(e.clip);
      else if (m_sat != SAT_MAX) m_sat = m_sat + int'(e.clip);
      m_out_cnt = (m_out_cnt + 1) % FP;
      if (e.fix_en) begin
        checks++;
        assert (bus.pixel_out === e.fix) else begin
          errors++;
          $error("FAIL directed_pixel cyc=%0d got %0d expected %0d", cyc, bus.pixel_out, e.fix);
        end
      end
    end
    checks++;
    assert (bus.pixel_out === last_pix) else begin
      errors++;
      $error("FAIL pixel_out cyc=%0d got %0d expected %0d", cyc, bus.pixel_out, last_pix);
    end
    checks++;
    assert (bus.frame_done === exp_fd) else begin
      errors++;
      $error("FAIL frame_done cyc=%0d got %b expected %b", cyc, bus.frame_done, exp_fd);
    end
    checks++;
    assert (bus.sat_count === m_sat[SW-1:0]) else begin
      errors++;
      $error("FAIL sat_count cyc=%0d got %0d expected %0d", cyc, bus.sat_count, m_sat);
    end
    if (bus.frame_done === 1'b1) fd_count++;
  endtask

  task automatic cycle(input bit v, input int acc, input int bias, input int unsigned scale,
                       input int shift, input bit relu, input bit fix_en, input byte fix);
    exp_t        e;
    int          ub;
    int unsigned us;
    int          ush;
    bit          ur;
    bus.valid_in = v;
    bus.acc_in   = acc;
    bus.bias     = bias;
    bus.scale    = scale[15:0];
    bus.shift    = shift[4:0];
    bus.relu_en  = relu;
    @(posedge clk);
    cyc++;
    if (v) begin
      if (m_in_cnt == 0) begin
        sh_bias = bias; sh_scale = scale[15:0]; sh_shift = shift[4:0]; sh_relu = relu;
      end
      ub = sh_bias; us = sh_scale; ush = sh_shift; ur = sh_relu;
      m_in_cnt = (m_in_cnt + 1) % FP;
      ref_calc(acc, ub, us, ush, ur, e.pix, e.clip);
      e.due = cyc + 3;
      e.fix_en = fix_en;
      e.fix = fix;
      expq.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  // Sends n accepted inputs; live config is either the given one or random noise.
  task automatic stream(input int n, input bit bubbles, input bit rand_cfg, input int bias,
                        input int unsigned scale, input int shift, input bit relu);
    int sent = 0;
    bit v;
    while (sent < n) begin
      v = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rand_cfg) begin
        cycle(v, rnd_acc(), $urandom_range(0, 4000) - 2000, $urandom_range(1, 400),
              $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'b0, 8'sd0);
      end else begin
        cycle(v, rnd_acc(), bias, scale, shift, relu, 1'b0, 8'sd0);
      end
      if (v) sent++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rnd_acc(), 0, 1, 0, 1'b0, 1'b0, 8'sd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.acc_in = '0; bus.bias = '0;
    bus.scale = '0; bus.shift = '0; bus.relu_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Basic scale/shift: (100*3 + 2) >>> 2 = 75.
    cycle(1'b1, 100, 0, 3, 2, 1'b0, 1'b1, 8'sd75);
    stream(FP - 1, 1'b0, 1'b1, 0, 0, 0, 1'b0);

    // Saturation both ways; second pixel uses the captured config, not the noisy live one.
    cycle(1'b1, 1000, 24, 1, 3, 1'b0, 1'b1, 8'sd127);
    cycle(1'b1, -5000, 777, 9, 0, 1'b1, 1'b1, -8'sd128);
    stream(FP - 2, 1'b0, 1'b1, 0, 0, 0, 1'b0);

    // Round-half-up.
    cycle(1'b1, -5, 0, 1, 1, 1'b0, 1'b1, -8'sd2);
    cycle(1'b1, 5, 0, 1, 1, 1'b0, 1'b1, 8'sd3);
    stream(FP - 2, 1'b1, 1'b1, 0, 0, 0, 1'b0);

    // ReLU on and off.
    cycle(1'b1, -100, 0, 1, 0, 1'b1, 1'b1, 8'sd0);
    stream(FP - 1, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    cycle(1'b1, -100, 0, 1, 0, 1'b0, 1'b1, -8'sd100);
    stream(FP - 1, 1'b1, 1'b1, 0, 0, 0, 1'b0);

    // Scale changes at input 5; only input 17 (next frame) picks it up.
    stream(4, 1'b1, 1'b0, 10, 5, 4, 1'b0);
    stream(FP - 4, 1'b1, 1'b0, 10, 9, 4, 1'b0);
    stream(1, 1'b1, 1'b0, 10, 9, 4, 1'b0);

    // Reset after input 7 of the frame: in-flight data is dropped.
    stream(6, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    expq.delete();
    m_in_cnt = 0; m_out_cnt = 0; m_sat = 0; last_pix = 0;
    check_outputs();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
    rst = 1'b0;

    fd_count = 0;
    stream(FP, 1'b1, 1'b1, 0, 0, 0, 1'b0);
    idle(6);
    checks++;
    assert (fd_count == 1) else begin
      errors++;
      $error("FAIL frame_done_count got %0d expected 1", fd_count);
    end
    checks++;
    assert (expq.size() == 0) else begin
      errors++;
      $error("FAIL outstanding_outputs got %0d expected 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after %0d cycles", cyc);
    $fatal(1);
  end

endmodule
